// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register offsets, status bit positions
// and the transfer state encoding.
package spi_target_pkg;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_RX     = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;

  localparam int STAT_RX_PENDING = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_BUSY       = 2;
  localparam int STAT_OVERRUN    = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer with a configurable preset value so that
// idle pin levels are seen as idle straight out of reset.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// Memory-mapped SPI target: oversamples the SPI pins in the system clock domain,
// shifts bytes MSB-first and exposes TX holding, RX data and status registers.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  logic sck_s, cs_s, mosi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(spi_sck), .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs), .q(cs_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s));

  state_e      state_d, state_q;
  logic        sck_prev_d, sck_prev_q;
  logic        cs_act_prev_d, cs_act_prev_q;
  logic [2:0]  bit_cnt_d, bit_cnt_q;
  logic [7:0]  shift_in_d, shift_in_q;
  logic [7:0]  shift_out_d, shift_out_q;
  logic [7:0]  tx_hold_d, tx_hold_q;
  logic [7:0]  rx_data_d, rx_data_q;
  logic        tx_empty_d, tx_empty_q;
  logic        rx_pending_d, rx_pending_q;
  logic        overrun_d, overrun_q;
  logic        miso_d, miso_q;
  logic        miso_oe_d, miso_oe_q;
  logic [31:0] rdata_d, rdata_q;

  logic       cs_act, sck_rise, sck_fall;
  logic       load_tx, byte_done;
  logic [7:0] next_byte;
  logic       unused_bits;

  assign cs_act      = ~cs_s;
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign next_byte   = tx_empty_q ? IDLE_BYTE : tx_hold_q;
  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  always_comb begin
    state_d       = state_q;
    sck_prev_d    = sck_s;
    cs_act_prev_d = cs_act;
    bit_cnt_d     = bit_cnt_q;
    shift_in_d    = shift_in_q;
    shift_out_d   = shift_out_q;
    tx_hold_d     = tx_hold_q;
    rx_data_d     = rx_data_q;
    tx_empty_d    = tx_empty_q;
    rx_pending_d  = rx_pending_q;
    overrun_d     = overrun_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rdata_d       = rdata_q;
    load_tx       = 1'b0;
    byte_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        miso_oe_d = 1'b0;
        if (cs_act && !cs_act_prev_q) begin
          state_d   = ST_ACTIVE;
          miso_oe_d = 1'b1;
          load_tx   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CS release wins over any SCK edge seen in the same cycle
        if (!cs_act) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          shift_in_d = {shift_in_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = {shift_in_q[6:0], mosi_s};
            bit_cnt_d = 3'd0;
            byte_done = 1'b1;
            load_tx   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
          miso_d      = shift_out_q[6];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_tx) begin
      shift_out_d = next_byte;
      miso_d      = next_byte[7];
      tx_empty_d  = 1'b1;
    end

    // Bus writes come after the byte-boundary load so a same-cycle TX write survives
    if (wen) begin
      case (addr[7:0])
        REG_DATA: begin
          tx_hold_d  = wdata[7:0];
          tx_empty_d = 1'b0;
        end
        REG_STATUS: begin
          if (wdata[STAT_RX_PENDING]) rx_pending_d = 1'b0;
          if (wdata[STAT_OVERRUN])    overrun_d    = 1'b0;
        end
        default: ;
      endcase
    end

    if (byte_done) begin
      rx_pending_d = 1'b1;
      if (rx_pending_q) overrun_d = 1'b1;
    end

    if (!wen) begin
      case (addr[7:0])
        REG_DATA:   rdata_d = {24'd0, tx_hold_q};
        REG_RX:     rdata_d = {24'd0, rx_data_q};
        REG_STATUS: rdata_d = {28'd0, overrun_q, (state_q == ST_ACTIVE), tx_empty_q, rx_pending_q};
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sck_prev_q    <= 1'b0;
      cs_act_prev_q <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shift_in_q    <= 8'd0;
      shift_out_q   <= 8'd0;
      tx_hold_q     <= 8'd0;
      rx_data_q     <= 8'd0;
      tx_empty_q    <= 1'b1;
      rx_pending_q  <= 1'b0;
      overrun_q     <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      sck_prev_q    <= sck_prev_d;
      cs_act_prev_q <= cs_act_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_in_q    <= shift_in_d;
      shift_out_q   <= shift_out_d;
      tx_hold_q     <= tx_hold_d;
      rx_data_q     <= rx_data_d;
      tx_empty_q    <= tx_empty_d;
      rx_pending_q  <= rx_pending_d;
      overrun_q     <= overrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;

endmodule
